branch_hazard_unit: RTL

- Companion to the ID-stage equality comparator used for early branch resolution (beq/bne decided in ID).
- Tracks destination info of in-flight instructions (EX, MEM, WB slots).
- Generates the comparator operand-forwarding selects, the stalls needed before the branch is evaluated, and the taken/flush decision from the comparator's Zero.
- Sits beside the hazard detection logic; drives the PC/IF-ID hold, the ID/EX bubble and the IF/ID flush.

---
 rtl/branch_hazard_unit_pkg.sv | 22 ++
 rtl/branch_hazard_unit_if.sv | 47 ++++
 rtl/branch_operand_resolve.sv | 43 ++++
 rtl/branch_hazard_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/branch_hazard_unit_pkg.sv
// Shared definitions for the ID-stage branch hazard unit.
//   - Forwarding select encodings for the branch comparator operands.
//   - slot_t: shadow record of one in-flight instruction (EX, MEM or WB).
//   - DEF_REG_ADDR_W: default register address width. slot_t is sized by it,
//     so REG_ADDR_W overrides on the modules must keep the same value.
package branch_hazard_unit_pkg;

   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_CNT_W      = 16;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b01;
   localparam logic [1:0] FWD_MEMWB   = 2'b10;

   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic                      mem_read;
      logic [DEF_REG_ADDR_W-1:0] dest;
   } slot_t;

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Signal bundle between the ID stage and the branch hazard unit.
//   master: ID stage side; drives the decoded instruction and comparator Zero,
//           receives stall / forwarding selects / taken / flush / counters.
//   slave : the hazard unit itself.
// Qualifier semantics: every id_* field is meaningful only while id_valid=1;
// there is no back-pressure handshake, stall is the only hold request and the
// ID stage must keep presenting the same instruction while it is high.
interface branch_hazard_unit_if
   import branch_hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int CNT_W      = DEF_CNT_W
) ();

   logic                  id_valid;
   logic                  id_is_branch;
   logic                  id_branch_ne;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic [REG_ADDR_W-1:0] id_dest;
   logic                  cmp_zero;

   logic                  stall;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  branch_taken;
   logic                  flush_ifid;
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      taken_count;

   modport master (
      output id_valid, id_is_branch, id_branch_ne, id_rs, id_rt,
             id_reg_write, id_mem_read, id_dest, cmp_zero,
      input  stall, fwd_a_sel, fwd_b_sel, branch_taken, flush_ifid,
             stall_cycles, taken_count
   );

   modport slave (
      input  id_valid, id_is_branch, id_branch_ne, id_rs, id_rt,
             id_reg_write, id_mem_read, id_dest, cmp_zero,
      output stall, fwd_a_sel, fwd_b_sel, branch_taken, flush_ifid,
             stall_cycles, taken_count
   );

endinterface

// File: rtl/branch_operand_resolve.sv
// Hazard resolution for one branch comparator operand.
//   reg_addr   : operand register number
//   ex/mem/wb  : shadow slots of the in-flight instructions
//   need_stall : producer still too far from the comparator to forward
//   fwd_sel    : comparator operand source (FWD_* encodings)
module branch_operand_resolve
   import branch_hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] reg_addr,
   input  slot_t                 ex_slot,
   input  slot_t                 mem_slot,
   input  slot_t                 wb_slot,
   output logic                  need_stall,
   output logic [1:0]            fwd_sel
);

   logic reg_nonzero;
   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   // $0 is hardwired, so a "write" to it never creates a dependency.
   assign reg_nonzero = (reg_addr != '0);
   assign ex_hit  = ex_slot.valid  & ex_slot.reg_write  & (ex_slot.dest  == reg_addr) & reg_nonzero;
   assign mem_hit = mem_slot.valid & mem_slot.reg_write & (mem_slot.dest == reg_addr) & reg_nonzero;
   assign wb_hit  = wb_slot.valid  & wb_slot.reg_write  & (wb_slot.dest  == reg_addr) & reg_nonzero;

   // Anything in EX has no result yet; a load in MEM has no data until WB.
   assign need_stall = ex_hit | (mem_hit & mem_slot.mem_read);

   // Youngest forwardable producer wins: EX/MEM ALU result beats MEM/WB data.
   always_comb begin
      fwd_sel = FWD_REGFILE;
      if (mem_hit && !mem_slot.mem_read) begin
         fwd_sel = FWD_EXMEM;
      end else if (wb_hit) begin
         fwd_sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/branch_hazard_unit.sv
// Branch hazard unit for early (ID-stage) beq/bne resolution.
// Shadows the EX/MEM/WB destination info of in-flight instructions and
// produces:
//   stall        : hold PC and IF/ID, bubble into ID/EX
//   fwd_a/b_sel  : comparator operand sources
//   branch_taken : branch resolves taken this cycle
//   flush_ifid   : squash the fetched instruction (same as branch_taken)
//   stall_cycles / taken_count : saturating statistics
// Ports: clk, reset (asynchronous, active-low), bus (slave modport).
module branch_hazard_unit
   import branch_hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   branch_hazard_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   slot_t            ex_q;
   slot_t            mem_q;
   slot_t            wb_q;
   slot_t            id_slot;
   logic             stall_a;
   logic             stall_b;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             is_branch;
   logic             stall_int;
   logic             taken_int;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] taken_cnt_q;

   branch_operand_resolve #(.REG_ADDR_W(REG_ADDR_W)) u_resolve_rs (
      .reg_addr   (bus.id_rs),
      .ex_slot    (ex_q),
      .mem_slot   (mem_q),
      .wb_slot    (wb_q),
      .need_stall (stall_a),
      .fwd_sel    (fwd_a)
   );

   branch_operand_resolve #(.REG_ADDR_W(REG_ADDR_W)) u_resolve_rt (
      .reg_addr   (bus.id_rt),
      .ex_slot    (ex_q),
      .mem_slot   (mem_q),
      .wb_slot    (wb_q),
      .need_stall (stall_b),
      .fwd_sel    (fwd_b)
   );

   // Gated with reset so stall/taken are quiet while reset is held, even if
   // ID presents a branch whose comparator already reads equal.
   assign is_branch = reset & bus.id_valid & bus.id_is_branch;
   assign stall_int = is_branch & (stall_a | stall_b);
   assign taken_int = is_branch & ~stall_int & (bus.cmp_zero ^ bus.id_branch_ne);

   assign id_slot = '{valid:     1'b1,
                      reg_write: bus.id_reg_write,
                      mem_read:  bus.id_mem_read,
                      dest:      bus.id_dest};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         taken_cnt_q <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         // A stalled branch stays in ID; EX receives a bubble instead.
         ex_q  <= (stall_int || !bus.id_valid) ? '0 : id_slot;
         if (stall_int && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (taken_int && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_q <= taken_cnt_q + 1'b1;
         end
      end
   end

   assign bus.stall        = stall_int;
   assign bus.fwd_a_sel    = fwd_a;
   assign bus.fwd_b_sel    = fwd_b;
   assign bus.branch_taken = taken_int;
   assign bus.flush_ifid   = taken_int;
   assign bus.stall_cycles = stall_cnt_q;
   assign bus.taken_count  = taken_cnt_q;

endmodule
